// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: sync, visible flag, pixel/character coordinates and strobes.
// The generator drives the master side; display renderers take the slave side.
interface vga_timing_gen_if;
  logic       hs;
  logic       vs;
  logic       video_on;
  logic [9:0] x;
  logic [9:0] y;
  logic [6:0] char_col;
  logic [4:0] char_row;
  logic       pix_tick;
  logic       frame_start;

  modport master (
    output hs, vs, video_on, x, y, char_col, char_row, pix_tick, frame_start
  );

  modport slave (
    input  hs, vs, video_on, x, y, char_col, char_row, pix_tick, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: divides clk to the pixel rate, runs h/v counters and
// registers sync, visible-area and coordinate outputs one clk behind the counters.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             step;
  logic             div_zero;

  logic       hs_q, vs_q, video_on_q, pix_tick_q, frame_start_q;
  logic [9:0] x_q, y_q;
  logic [6:0] char_col_q;
  logic [4:0] char_row_q;

  logic h_vis, v_vis, h_sync, v_sync;

  assign step     = (div == DIV_LAST);
  assign div_zero = (div == '0);

  // Pixel divider and raster counters; v_cnt advances only on the h wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div   <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      div <= step ? '0 : div + 1'b1;
      if (step) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  assign h_vis  = (h_cnt < H_VIS);
  assign v_vis  = (v_cnt < V_VIS);
  assign h_sync = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign v_sync = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // All outputs share one register stage so sync, flag and coordinates never skew.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      char_col_q    <= '0;
      char_row_q    <= '0;
    end else begin
      hs_q          <= h_sync ? SYNC_POL : ~SYNC_POL;
      vs_q          <= v_sync ? SYNC_POL : ~SYNC_POL;
      video_on_q    <= h_vis && v_vis;
      pix_tick_q    <= div_zero;
      frame_start_q <= div_zero && (h_cnt == '0) && (v_cnt == '0);
      x_q           <= h_cnt;
      y_q           <= v_cnt;
      char_col_q    <= h_cnt[9:3];
      char_row_q    <= v_cnt[8:4];
    end
  end

  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.video_on    = video_on_q;
  assign vga.pix_tick    = pix_tick_q;
  assign vga.frame_start = frame_start_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.char_col    = char_col_q;
  assign vga.char_row    = char_row_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, and a reduced raster at
// CLK_DIV 2 and 1) checked every clk against an arithmetic model of the raster.
module tb_vga_timing_gen;

  typedef struct packed {
    int cd, ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
  } cfg_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic [6:0] char_col;
    logic [4:0] char_row;
    logic       pix_tick;
    logic       frame_start;
  } out_t;

  localparam cfg_t CFG_A = '{cd:2, ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33};
  localparam cfg_t CFG_B = '{cd:2, ha:40,  hfp:4,  hsw:8,  hbp:6,  va:20,  vfp:2,  vsw:2, vbp:3};
  localparam cfg_t CFG_C = '{cd:1, ha:40,  hfp:4,  hsw:8,  hbp:6,  va:20,  vfp:2,  vsw:2, vbp:3};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if a_if ();
  vga_timing_gen_if b_if ();
  vga_timing_gen_if c_if ();

  vga_timing_gen u_a (.clk(clk), .rst(rst), .vga(a_if));

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u_b (.clk(clk), .rst(rst), .vga(b_if));

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u_c (.clk(clk), .rst(rst), .vga(c_if));

  out_t got_a, got_b, got_c;
  assign got_a = {a_if.hs, a_if.vs, a_if.video_on, a_if.x, a_if.y, a_if.char_col,
                  a_if.char_row, a_if.pix_tick, a_if.frame_start};
  assign got_b = {b_if.hs, b_if.vs, b_if.video_on, b_if.x, b_if.y, b_if.char_col,
                  b_if.char_row, b_if.pix_tick, b_if.frame_start};
  assign got_c = {c_if.hs, c_if.vs, c_if.video_on, c_if.x, c_if.y, c_if.char_col,
                  c_if.char_row, c_if.pix_tick, c_if.frame_start};

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t     = -1;   // clks since the first edge after reset release (E1 = 0)
  int last_fs_b = -1;
  int last_fs_c = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs t clks after E1, straight from the raster arithmetic.
  function automatic out_t model(input cfg_t c, input int tt);
    out_t o;
    int p, x, y, htot, vtot;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (tt < 0) return o;
    htot = c.ha + c.hfp + c.hsw + c.hbp;
    vtot = c.va + c.vfp + c.vsw + c.vbp;
    p = tt / c.cd;
    x = p % htot;
    y = (p / htot) % vtot;
    o.x           = 10'(x);
    o.y           = 10'(y);
    o.char_col    = 7'(x / 8);
    o.char_row    = 5'((y / 16) % 32);
    o.video_on    = (x < c.ha) && (y < c.va);
    o.hs          = !((x >= c.ha + c.hfp) && (x < c.ha + c.hfp + c.hsw));
    o.vs          = !((y >= c.va + c.vfp) && (y < c.va + c.vfp + c.vsw));
    o.pix_tick    = (tt % c.cd) == 0;
    o.frame_start = o.pix_tick && x == 0 && y == 0;
    return o;
  endfunction

  task automatic cmp_out(input string n, input out_t g, input out_t e);
    check({n, ".hs"},          32'(g.hs),          32'(e.hs));
    check({n, ".vs"},          32'(g.vs),          32'(e.vs));
    check({n, ".video_on"},    32'(g.video_on),    32'(e.video_on));
    check({n, ".x"},           32'(g.x),           32'(e.x));
    check({n, ".y"},           32'(g.y),           32'(e.y));
    check({n, ".char_col"},    32'(g.char_col),    32'(e.char_col));
    check({n, ".char_row"},    32'(g.char_row),    32'(e.char_row));
    check({n, ".pix_tick"},    32'(g.pix_tick),    32'(e.pix_tick));
    check({n, ".frame_start"}, 32'(g.frame_start), 32'(e.frame_start));
  endtask

  function automatic int frame_clks(input cfg_t c);
    return c.cd * (c.ha + c.hfp + c.hsw + c.hbp) * (c.va + c.vfp + c.vsw + c.vbp);
  endfunction

  // One clk: drive rst away from the edge, advance the model, sample after the edge.
  task automatic cycle(input logic r);
    @(negedge clk);
    rst = r;
    @(posedge clk);
    cyc++;
    t = r ? t + 1 : -1;
    #1;
    cmp_out("a", got_a, model(CFG_A, t));
    cmp_out("b", got_b, model(CFG_B, t));
    cmp_out("c", got_c, model(CFG_C, t));
    if (!r) begin
      last_fs_b = -1;
      last_fs_c = -1;
    end else begin
      if (got_b.frame_start === 1'b1) begin
        if (last_fs_b >= 0) check("b.frame_period", 32'(cyc - last_fs_b), 32'(frame_clks(CFG_B)));
        last_fs_b = cyc;
      end
      if (got_c.frame_start === 1'b1) begin
        if (last_fs_c >= 0) check("c.frame_period", 32'(cyc - last_fs_c), 32'(frame_clks(CFG_C)));
        last_fs_c = cyc;
      end
      if (t >= 0 && got_a.x == 10'd656) check("a.char_col_656", 32'(got_a.char_col), 32'd82);
    end
  endtask

  initial begin
    repeat (5) cycle(1'b0);
    // Long first run: several full reduced frames and a few full 800-pixel lines.
    repeat (7000) cycle(1'b1);
    cycle(1'b0);
    repeat (4) begin
      repeat ($urandom_range(2500, 50)) cycle(1'b1);
      repeat ($urandom_range(3, 1)) cycle(1'b0);
    end
    repeat (3500) cycle(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
